// File: rtl/dct16_row_sched_if.sv
// Row handshake and tagged-output bundle between the DCT row producer/consumer and dct16_row_sched.
interface dct16_row_sched_if #(
   parameter int unsigned ROWS = 16
);
   localparam int unsigned RW = $clog2(ROWS);

   logic          in_valid;
   logic          in_ready;
   logic          abort;
   logic          out_afull;
   logic          core_load;
   logic          out_valid;
   logic [RW-1:0] out_row;
   logic          out_first;
   logic          out_last;
   logic          blk_done;
   logic          busy;
   logic [15:0]   blk_cnt;

   modport master (
      output in_valid, abort, out_afull,
      input  in_ready, core_load, out_valid, out_row, out_first, out_last,
             blk_done, busy, blk_cnt
   );

   modport slave (
      input  in_valid, abort, out_afull,
      output in_ready, core_load, out_valid, out_row, out_first, out_last,
             blk_done, busy, blk_cnt
   );
endinterface

// File: rtl/dct16_row_sched.sv
// Row admission and result tagging for the 16-point DCT core: a tag pipeline matched to the
// core latency labels every core output with row index, block-boundary flags and a done pulse.
module dct16_row_sched #(
   parameter int unsigned LATENCY = 6,
   parameter int unsigned ROWS    = 16
) (
   input logic               clk,
   input logic               rst,
   dct16_row_sched_if.slave  bus
);
   localparam int unsigned RW = $clog2(ROWS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [RW-1:0]        wr_row_q, wr_row_d;
   logic [LATENCY-1:0]   tv_q, tv_d;
   logic [LATENCY-1:0]   tf_q, tf_d;
   logic [LATENCY-1:0]   tl_q, tl_d;
   logic [RW-1:0]        tr_q [LATENCY];
   logic [RW-1:0]        tr_d [LATENCY];
   logic                 blk_done_q, blk_done_d;
   logic                 busy_q, busy_d;
   logic [15:0]          blk_cnt_q, blk_cnt_d;
   logic                 ready_c;
   logic                 load_c;
   logic                 last_pend_c;

   // Admission is purely a function of abort/back-pressure; the core cannot stall later.
   always_comb begin
      ready_c = !bus.abort && !bus.out_afull;
      load_c  = bus.in_valid && ready_c;
   end

   assign bus.in_ready  = ready_c;
   assign bus.core_load = load_c;

   // Tag pipeline shifts every cycle; the final stage is the registered output.
   always_comb begin
      tv_d = '0;
      tf_d = '0;
      tl_d = '0;
      for (int k = 0; k < int'(LATENCY); k++) begin
         tr_d[k] = '0;
      end
      tv_d[0] = load_c;
      tr_d[0] = wr_row_q;
      tf_d[0] = (wr_row_q == '0);
      tl_d[0] = (wr_row_q == RW'(ROWS - 1));
      for (int k = 1; k < int'(LATENCY); k++) begin
         tv_d[k] = tv_q[k-1];
         tr_d[k] = tr_q[k-1];
         tf_d[k] = tf_q[k-1];
         tl_d[k] = tl_q[k-1];
      end
      if (bus.abort) begin
         tv_d = '0;
      end
      blk_done_d = tv_d[LATENCY-1] && tl_d[LATENCY-1];
   end

   // A last-of-block tag still upstream of the output stage keeps DRAIN alive.
   always_comb begin
      last_pend_c = 1'b0;
      for (int k = 0; k < int'(LATENCY) - 1; k++) begin
         last_pend_c = last_pend_c | (tv_q[k] & tl_q[k]);
      end
   end

   // Block state, write row counter, completion counter and busy.
   always_comb begin
      state_d   = state_q;
      wr_row_d  = wr_row_q;
      blk_cnt_d = blk_cnt_q + 16'(blk_done_q);
      if (bus.abort) begin
         state_d  = S_IDLE;
         wr_row_d = '0;
      end else if (load_c) begin
         wr_row_d = wr_row_q + RW'(1);
         state_d  = (wr_row_q == RW'(ROWS - 1)) ? S_DRAIN : S_RUN;
      end else if (state_q == S_DRAIN && blk_done_q && !last_pend_c) begin
         state_d = S_IDLE;
      end
      busy_d = (state_d != S_IDLE) || (|tv_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_row_q   <= '0;
         tv_q       <= '0;
         tf_q       <= '0;
         tl_q       <= '0;
         for (int k = 0; k < int'(LATENCY); k++) begin
            tr_q[k] <= '0;
         end
         blk_done_q <= 1'b0;
         busy_q     <= 1'b0;
         blk_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_row_q   <= wr_row_d;
         tv_q       <= tv_d;
         tf_q       <= tf_d;
         tl_q       <= tl_d;
         for (int k = 0; k < int'(LATENCY); k++) begin
            tr_q[k] <= tr_d[k];
         end
         blk_done_q <= blk_done_d;
         busy_q     <= busy_d;
         blk_cnt_q  <= blk_cnt_d;
      end
   end

   assign bus.out_valid = tv_q[LATENCY-1];
   assign bus.out_row   = tr_q[LATENCY-1];
   assign bus.out_first = tf_q[LATENCY-1];
   assign bus.out_last  = tl_q[LATENCY-1];
   assign bus.blk_done  = blk_done_q;
   assign bus.busy      = busy_q;
   assign bus.blk_cnt   = blk_cnt_q;
endmodule
